// File: rtl/btn_event_ctrl.sv
// Button gesture sequencer: debounced level in, one-cycle press/release/click/dbl/long/repeat pulses out.
// Optional auto-repeat in HELD when BTN_EVENT_REPEAT_EN is defined; release/repeat carry _ev since both are SV keywords.
module btn_event_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 800,
  parameter int DBL_MS    = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic release_ev,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic repeat_ev,
  output logic busy
);

  // state | meaning
  // IDLE  | waiting for first press
  // DOWN1 | first press held, timing long-press
  // WAIT2 | released once, timing gap for a second press
  // DOWN2 | second press held, timing long-press
  // HELD  | long-press declared, waiting for release (auto-repeat if enabled)
  typedef enum logic [2:0] {IDLE, DOWN1, WAIT2, DOWN2, HELD} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t     state, state_nxt;
  logic [PW-1:0] presc;
  logic [11:0] ms_cnt;
  logic       btn_q;
  logic       tick, rise, fall, ms_clr;
  logic       to_long, to_dbl;
  logic       press_nxt, release_nxt, click_nxt, dbl_nxt, long_nxt;

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign rise    = btn_in & ~btn_q;
  assign fall    = ~btn_in & btn_q;
  assign to_long = tick && (ms_cnt == 12'(LONG_MS));
  assign to_dbl  = tick && (ms_cnt == 12'(DBL_MS));
  assign busy    = (state != IDLE);

`ifdef BTN_EVENT_REPEAT_EN
  logic to_rpt, rpt_nxt;
  // HELD entry and each repeat land on a tick, so compare one short to get an exact REPEAT_MS period.
  assign to_rpt = tick && (ms_cnt == 12'(REPEAT_MS - 1));
  assign ms_clr = (state_nxt != state) || rpt_nxt;
`else
  assign ms_clr    = (state_nxt != state);
  assign repeat_ev = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    dbl_nxt     = 1'b0;
    long_nxt    = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
    rpt_nxt     = 1'b0;
`endif
    case (state)
      IDLE: if (rise) begin
        press_nxt = 1'b1;
        state_nxt = DOWN1;
      end
      DOWN1: if (fall) begin
        release_nxt = 1'b1;
        state_nxt   = WAIT2;
      end else if (to_long) begin
        long_nxt  = 1'b1;
        state_nxt = HELD;
      end
      WAIT2: if (rise) begin
        press_nxt = 1'b1;
        state_nxt = DOWN2;
      end else if (to_dbl) begin
        click_nxt = 1'b1;
        state_nxt = IDLE;
      end
      DOWN2: if (fall) begin
        release_nxt = 1'b1;
        dbl_nxt     = 1'b1;
        state_nxt   = IDLE;
      end else if (to_long) begin
        long_nxt  = 1'b1;
        state_nxt = HELD;
      end
      HELD: if (fall) begin
        release_nxt = 1'b1;
        state_nxt   = IDLE;
      end
`ifdef BTN_EVENT_REPEAT_EN
      else if (to_rpt) begin
        rpt_nxt = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      btn_q      <= 1'b0;
      presc      <= '0;
      ms_cnt     <= '0;
      press      <= 1'b0;
      release_ev <= 1'b0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nxt;
      btn_q      <= btn_in;
      presc      <= tick ? '0 : presc + PW'(1);
      if (ms_clr)
        ms_cnt <= '0;
      else if (tick && ms_cnt != 12'hfff)
        ms_cnt <= ms_cnt + 12'd1;
      press      <= press_nxt;
      release_ev <= release_nxt;
      click      <= click_nxt;
      dbl_click  <= dbl_nxt;
      long_press <= long_nxt;
    end
  end

`ifdef BTN_EVENT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_ev <= 1'b0;
    else     repeat_ev <= rpt_nxt;
  end
`endif

endmodule
